multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_defs.sv | 31 +++
 rtl/mc_output_decode.sv | 85 ++++++++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes
// and the ALU operation codes consumed by the ALU control stage.
package cpu_defs;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RCOMP   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output table: maps the current control state to every datapath
// enable/select. Unused encodings fall through to all-zero.
module mc_output_decode
  import cpu_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] State,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               AluSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         Aluop
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    AluSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    AluSrcB     = 2'b00;
    Aluop       = ALU_ADD;
    case (State)
      STATE_W'(FETCH): begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        AluSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      STATE_W'(DECODE):  AluSrcB = 2'b11;
      STATE_W'(MEMADDR), STATE_W'(ADDIEX): begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
      end
      STATE_W'(MEMRD): begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      STATE_W'(MEMWB): begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      STATE_W'(MEMWR): begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      STATE_W'(EXEC): begin
        AluSrcA = 1'b1;
        Aluop   = ALU_FUNC;
      end
      STATE_W'(RCOMP): begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      STATE_W'(BRANCH): begin
        AluSrcA     = 1'b1;
        Aluop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      STATE_W'(JUMP): begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      STATE_W'(ADDIWB):  RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register, opcode latch and next-state
// logic; outputs come from the state table with write enables masked in reset.
module multicycle_control
  import cpu_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               AluSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         AluSrcB,
  output logic [1:0]         Aluop,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [5:0]         op_q;
  logic               illegal_d;
  logic               pcwrite_raw, pcwritecond_raw, memread_raw;
  logic               memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STATE_W'(FETCH);
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      if (state_q == STATE_W'(DECODE)) op_q <= Opcode;
    end
  end

  always_comb begin
    state_d   = STATE_W'(FETCH);
    illegal_d = 1'b0;
    case (state_q)
      STATE_W'(FETCH): state_d = STATE_W'(DECODE);
      STATE_W'(DECODE): begin
        case (Opcode)
          OP_LW, OP_SW: state_d = STATE_W'(MEMADDR);
          OP_RTYPE:     state_d = STATE_W'(EXEC);
          OP_BEQ:       state_d = STATE_W'(BRANCH);
          OP_J:         state_d = STATE_W'(JUMP);
          OP_ADDI:      state_d = STATE_W'(ADDIEX);
          default:      illegal_d = 1'b1;
        endcase
      end
      // Opcode input may already hold the next instruction here; use the latch.
      STATE_W'(MEMADDR): state_d = (op_q == OP_LW) ? STATE_W'(MEMRD) : STATE_W'(MEMWR);
      STATE_W'(MEMRD):   state_d = STATE_W'(MEMWB);
      STATE_W'(EXEC):    state_d = STATE_W'(RCOMP);
      STATE_W'(ADDIEX):  state_d = STATE_W'(ADDIWB);
      default:           state_d = STATE_W'(FETCH);
    endcase
  end

  mc_output_decode #(.STATE_W(STATE_W)) u_decode (
    .State       (state_q),
    .PCWrite     (pcwrite_raw),
    .PCWriteCond (pcwritecond_raw),
    .IorD        (IorD),
    .MemRead     (memread_raw),
    .MemWrite    (memwrite_raw),
    .MemtoReg    (MemtoReg),
    .IRWrite     (irwrite_raw),
    .AluSrcA     (AluSrcA),
    .RegWrite    (regwrite_raw),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .AluSrcB     (AluSrcB),
    .Aluop       (Aluop)
  );

  assign PCWrite     = pcwrite_raw     & ~reset;
  assign PCWriteCond = pcwritecond_raw & ~reset;
  assign MemRead     = memread_raw     & ~reset;
  assign MemWrite    = memwrite_raw    & ~reset;
  assign IRWrite     = irwrite_raw     & ~reset;
  assign RegWrite    = regwrite_raw    & ~reset;
  assign Illegal     = illegal_d       & ~reset;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks the control outputs cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, AluSrcA, RegWrite, RegDst, Illegal;
  logic [1:0] PCSource, AluSrcB, Aluop;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .AluSrcA     (AluSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .AluSrcB     (AluSrcB),
    .Aluop       (Aluop),
    .Illegal     (Illegal),
    .State       (State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    Opcode = 6'b000000;
    repeat (2) tick();
    chk("rst_state", 8'(State), 8'd0);
    chk("rst_pcwrite", 8'(PCWrite), 8'd0);
    chk("rst_memread", 8'(MemRead), 8'd0);
    chk("rst_irwrite", 8'(IRWrite), 8'd0);
    chk("rst_illegal", 8'(Illegal), 8'd0);
    chk("rst_alusrcb", 8'(AluSrcB), 8'd1);

    // lw: 0,1,2,3,4,0
    reset  = 1'b0;
    Opcode = 6'b100011;
    #1;
    chk("lw_fetch_state", 8'(State), 8'd0);
    chk("lw_fetch_en", {3'b0, MemRead, IRWrite, PCWrite, IorD, RegWrite}, 8'b00011100);
    tick();
    chk("lw_decode_state", 8'(State), 8'd1);
    chk("lw_decode_srcb", 8'(AluSrcB), 8'd3);
    chk("lw_decode_rw", 8'(RegWrite), 8'd0);
    tick();
    chk("lw_memaddr_state", 8'(State), 8'd2);
    chk("lw_memaddr_sel", {5'b0, AluSrcA, AluSrcB}, 8'b00000110);
    tick();
    chk("lw_memrd_state", 8'(State), 8'd3);
    chk("lw_memrd_en", {5'b0, MemRead, IorD, RegWrite}, 8'b00000110);
    tick();
    chk("lw_memwb_state", 8'(State), 8'd4);
    chk("lw_memwb_en", {5'b0, RegWrite, MemtoReg, RegDst}, 8'b00000110);
    tick();
    chk("lw_back_fetch", 8'(State), 8'd0);
    chk("lw_fetch_rw", {6'b0, RegWrite, MemtoReg}, 8'd0);

    // R-type: 0,1,6,7,0
    Opcode = 6'b000000;
    tick();
    chk("r_decode", 8'(State), 8'd1);
    tick();
    chk("r_exec_state", 8'(State), 8'd6);
    chk("r_exec_aluop", 8'(Aluop), 8'd2);
    chk("r_exec_srca", 8'(AluSrcA), 8'd1);
    tick();
    chk("r_rcomp_state", 8'(State), 8'd7);
    chk("r_rcomp_en", {5'b0, RegWrite, RegDst, MemtoReg}, 8'b00000110);
    tick();
    chk("r_back_fetch", 8'(State), 8'd0);

    // beq then j
    Opcode = 6'b000100;
    tick();
    tick();
    chk("beq_state", 8'(State), 8'd8);
    chk("beq_sel", {3'b0, PCWriteCond, PCSource, Aluop}, 8'b00010101);
    chk("beq_pcwrite", 8'(PCWrite), 8'd0);
    tick();
    chk("beq_back_fetch", 8'(State), 8'd0);
    Opcode = 6'b000010;
    tick();
    tick();
    chk("j_state", 8'(State), 8'd9);
    chk("j_sel", {5'b0, PCWrite, PCSource}, 8'b00000110);
    tick();
    chk("j_back_fetch", 8'(State), 8'd0);

    // illegal opcode
    Opcode = 6'b111111;
    chk("ill_fetch_pulse", 8'(Illegal), 8'd0);
    tick();
    chk("ill_decode_state", 8'(State), 8'd1);
    chk("ill_decode_pulse", 8'(Illegal), 8'd1);
    chk("ill_decode_wr", {6'b0, RegWrite, MemWrite}, 8'd0);
    tick();
    chk("ill_next_state", 8'(State), 8'd0);
    chk("ill_pulse_gone", 8'(Illegal), 8'd0);

    // sw with Opcode changed during MEMADDR
    Opcode = 6'b101011;
    tick();
    tick();
    chk("sw_memaddr", 8'(State), 8'd2);
    Opcode = 6'b000000;
    tick();
    chk("sw_memwr_state", 8'(State), 8'd5);
    chk("sw_memwr_en", {5'b0, MemWrite, IorD, MemRead}, 8'b00000110);
    tick();
    chk("sw_back_fetch", 8'(State), 8'd0);
    chk("sw_memwrite_off", 8'(MemWrite), 8'd0);

    // addi: 0,1,10,11,0
    Opcode = 6'b001000;
    tick();
    tick();
    chk("addi_ex_state", 8'(State), 8'd10);
    chk("addi_ex_sel", {5'b0, AluSrcA, AluSrcB}, 8'b00000110);
    tick();
    chk("addi_wb_state", 8'(State), 8'd11);
    chk("addi_wb_en", {5'b0, RegWrite, RegDst, MemtoReg}, 8'b00000100);
    tick();
    chk("addi_back_fetch", 8'(State), 8'd0);

    // reset during MEMRD
    Opcode = 6'b100011;
    tick();
    tick();
    tick();
    chk("rmid_memrd_state", 8'(State), 8'd3);
    chk("rmid_memrd_rd", 8'(MemRead), 8'd1);
    reset = 1'b1;
    #1;
    chk("rmid_en_masked", {4'b0, MemRead, MemWrite, RegWrite, PCWrite}, 8'd0);
    chk("rmid_iord_kept", 8'(IorD), 8'd1);
    tick();
    chk("rmid_state_fetch", 8'(State), 8'd0);
    chk("rmid_pcwrite_masked", 8'(PCWrite), 8'd0);
    reset = 1'b0;
    #1;
    chk("rmid_release_en", {5'b0, PCWrite, MemRead, IRWrite}, 8'b00000111);
    tick();
    chk("rmid_release_decode", 8'(State), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
